fp16_exponent_align: RTL

//  Operand-alignment stage in front of the exponent mux of the FP16 add/sub datapath.

---
 rtl/fp16_pkg.sv | 24 ++
 rtl/fp16_exponent_align_if.sv | 32 +++
 rtl/fp16_unpack.sv | 22 ++
 rtl/fp16_exponent_align.sv | 116 +++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared types and widths for the FP16 operand-alignment stage.
// Holds field widths, the packed FP16 layout and the alignment FSM states.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int SIG_W  = FRAC_W + 4;
    localparam int CNT_W  = $clog2(SIG_W);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } align_state_t;

endpackage

// File: rtl/fp16_exponent_align_if.sv
// Handshake + data bundle of the alignment stage.
// slave: the stage itself; master: the operand source / result sink.
interface fp16_exponent_align_if;
    import fp16_pkg::*;

    logic              in_valid;
    logic              in_ready;
    fp16_t             a;
    fp16_t             b;
    logic              out_valid;
    logic              out_ready;
    logic              exp_sel;
    logic [EXP_W-1:0]  exp_max;
    logic              sign_big;
    logic              sign_small;
    logic [SIG_W-1:0]  sig_big;
    logic [SIG_W-1:0]  sig_small;
    logic              special;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, exp_sel, exp_max,
        output sign_big, sign_small, sig_big, sig_small, special
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, exp_sel, exp_max,
        input  sign_big, sign_small, sig_big, sig_small, special
    );

endinterface

// File: rtl/fp16_unpack.sv
// Combinational FP16 unpack: sign, effective exponent, {hidden,frac,GRS}.
// Ports: op in; sign, eff_exp, sig, is_special out.
module fp16_unpack
    import fp16_pkg::*;
(
    input  fp16_t             op,
    output logic              sign,
    output logic [EXP_W-1:0]  eff_exp,
    output logic [SIG_W-1:0]  sig,
    output logic              is_special
);

    logic hidden;

    // Subnormals share exponent 1 with the smallest normals.
    assign hidden     = |op.exp;
    assign sign       = op.sign;
    assign eff_exp    = hidden ? op.exp : EXP_W'(1);
    assign sig        = {hidden, op.frac, 3'b000};
    assign is_special = (op.exp == EXP_ONES);

endmodule

// File: rtl/fp16_exponent_align.sv
// FP16 add/sub alignment: exponent compare, serial sticky right-shift.
// Ports: clk, rst_n (async, active low), bus (slave side of the stage bundle).
module fp16_exponent_align
    import fp16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    fp16_exponent_align_if.slave bus
);

    localparam logic [EXP_W-1:0] SIG_W_E = EXP_W'(SIG_W);

    align_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              exp_sel_q, sign_big_q, sign_small_q, special_q;
    logic [EXP_W-1:0]  exp_max_q;
    logic [SIG_W-1:0]  sig_big_q, sig_small_q;

    fp16_t             op_a, op_b;
    logic              sgn_a, sgn_b, spc_a, spc_b;
    logic [EXP_W-1:0]  eff_a, eff_b;
    logic [SIG_W-1:0]  sig_a, sig_b;

    logic              accept, a_ge_b, special_d, far;
    logic [EXP_W-1:0]  diff;
    logic [SIG_W-1:0]  small_d;

    assign op_a = bus.a;
    assign op_b = bus.b;

    fp16_unpack u_unpack_a (
        .op         (op_a),
        .sign       (sgn_a),
        .eff_exp    (eff_a),
        .sig        (sig_a),
        .is_special (spc_a)
    );

    fp16_unpack u_unpack_b (
        .op         (op_b),
        .sign       (sgn_b),
        .eff_exp    (eff_b),
        .sig        (sig_b),
        .is_special (spc_b)
    );

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign a_ge_b    = (eff_a >= eff_b);
    assign diff      = a_ge_b ? (eff_a - eff_b) : (eff_b - eff_a);
    assign special_d = spc_a | spc_b;
    assign small_d   = a_ge_b ? sig_b : sig_a;
    // Shifting everything out leaves only the sticky bit.
    assign far       = !special_d && (diff >= SIG_W_E);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (special_d || diff == '0 || far) state_d = HOLD;
                    else                                state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(1)) state_d = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            exp_sel_q    <= 1'b0;
            exp_max_q    <= '0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            sig_big_q    <= '0;
            sig_small_q  <= '0;
            special_q    <= 1'b0;
        end else if (accept) begin
            exp_sel_q    <= a_ge_b;
            exp_max_q    <= a_ge_b ? eff_a : eff_b;
            sign_big_q   <= a_ge_b ? sgn_a : sgn_b;
            sign_small_q <= a_ge_b ? sgn_b : sgn_a;
            sig_big_q    <= a_ge_b ? sig_a : sig_b;
            special_q    <= special_d;
            sig_small_q  <= far ? {{(SIG_W-1){1'b0}}, |small_d} : small_d;
            cnt_q        <= (special_d || far) ? '0 : diff[CNT_W-1:0];
        end else if (state_q == SHIFT) begin
            // Bits falling off the end fold into the LSB sticky.
            sig_small_q  <= {1'b0, sig_small_q[SIG_W-1:2],
                             |sig_small_q[1:0]};
            cnt_q        <= cnt_q - CNT_W'(1);
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.exp_sel    = exp_sel_q;
    assign bus.exp_max    = exp_max_q;
    assign bus.sign_big   = sign_big_q;
    assign bus.sign_small = sign_small_q;
    assign bus.sig_big    = sig_big_q;
    assign bus.sig_small  = sig_small_q;
    assign bus.special    = special_q;

endmodule
